line_buf_ctrl: RTL and testbench

- Sequencer in front of the two-line cascaded shift-register column buffer used by the bilinear interpolator.
- The buffer moves every cycle: it shifts when enabled and self-rotates when idle. Vertical alignment between rows therefore requires every row to start on the same cycle phase modulo IMG_W and to be written in IMG_W contiguous cycles.
- This block gates the upstream pixel stream to enforce that rule, drives the buffer enable and data, and tags the buffer outputs with row/column coordinates and a valid pair strobe.

---
 rtl/line_buf_pkg.sv | 25 ++
 rtl/line_buf_if.sv | 12 +
 rtl/line_phase_cnt.sv | 24 ++
 rtl/line_buf_ctrl.sv | 143 ++++++++++++++
 tb/tb_line_buf_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared state type, default geometry and counter sizing helpers
package line_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    GAP  = 2'd2
  } lb_state_e;

  localparam int LB_IMG_W = 1280;
  localparam int LB_IMG_H = 720;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int col_w(input int img_w);
    return cnt_w(img_w);
  endfunction

  function automatic int row_w(input int img_h);
    return cnt_w(img_h);
  endfunction

endpackage

// File: rtl/line_buf_if.sv
// rtl/line_buf_if.sv - upstream pixel stream into the line buffer sequencer
interface line_buf_if #(
  parameter int DW = 8
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_sof;

  modport master (output s_valid, output s_data, output s_sof, input s_ready);
  modport slave  (input s_valid, input s_data, input s_sof, output s_ready);
endinterface

// File: rtl/line_phase_cnt.sv
// rtl/line_phase_cnt.sv - free-running modulo-IMG_W write phase with terminal-count flag
module line_phase_cnt
  import line_buf_pkg::*;
#(
  parameter int IMG_W = LB_IMG_W,
  parameter int CW    = col_w(IMG_W)
) (
  input  logic clk,
  input  logic rst_n,
  output logic tc_o
);
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);

  logic [CW-1:0] phase_q;
  logic [CW-1:0] phase_d;

  assign tc_o    = (phase_q == LAST);
  assign phase_d = tc_o ? '0 : phase_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end
endmodule

// File: rtl/line_buf_ctrl.sv
// rtl/line_buf_ctrl.sv - phase-locked row sequencer and pair tagger for the cascaded column buffer
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int IMG_W = LB_IMG_W,
  parameter int IMG_H = LB_IMG_H,
  parameter int DW    = 8,
  parameter int CW    = col_w(IMG_W),
  parameter int RW    = row_w(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  line_buf_if.slave     s,
  output logic          buf_en,
  output logic [DW-1:0] buf_data,
  output logic          pair_valid,
  output logic [CW-1:0] pair_col,
  output logic [RW-1:0] pair_row,
  output logic          pair_eol,
  output logic          pair_eof,
  output logic          frame_busy,
  output logic          frame_done,
  output logic          err_underrun,
  output logic          err_sof,
  input  logic          err_clr
);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic tc;
  line_phase_cnt #(.IMG_W(IMG_W), .CW(CW)) u_phase (
    .clk  (clk),
    .rst_n(rst_n),
    .tc_o (tc)
  );

  lb_state_e     state_q;
  logic [CW-1:0] col_q, wr_col_q, pair_col_q;
  logic [RW-1:0] row_q, wr_row_q, pair_row_q;
  logic [DW-1:0] buf_data_q;
  logic          buf_en_q, pair_valid_q, pair_eol_q, pair_eof_q;
  logic          busy_q, err_ur_q, err_sof_q;
  logic          rdy, accept, row_start, wr_pair;

  always_comb begin
    rdy = 1'b0;
    case (state_q)
      IDLE:    rdy = !s.s_sof | tc;
      ROW:     rdy = 1'b1;
      GAP:     rdy = tc;
      default: rdy = 1'b0;
    endcase
  end

  assign s.s_ready = rdy;
  assign accept    = s.s_valid & rdy;
  // A row may only open on the last phase so its writes land on phases 0..IMG_W-1.
  assign row_start = accept & tc & (((state_q == IDLE) & s.s_sof) | (state_q == GAP));
  assign wr_pair   = buf_en_q & (wr_row_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      buf_en_q     <= 1'b0;
      buf_data_q   <= '0;
      wr_col_q     <= '0;
      wr_row_q     <= '0;
      pair_valid_q <= 1'b0;
      pair_col_q   <= '0;
      pair_row_q   <= '0;
      pair_eol_q   <= 1'b0;
      pair_eof_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_ur_q     <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      buf_en_q     <= 1'b0;
      pair_valid_q <= wr_pair;
      pair_col_q   <= wr_col_q;
      pair_row_q   <= wr_row_q;
      pair_eol_q   <= wr_pair & (wr_col_q == COL_LAST);
      pair_eof_q   <= wr_pair & (wr_col_q == COL_LAST) & (wr_row_q == ROW_LAST);

      if (err_clr) begin
        err_ur_q  <= 1'b0;
        err_sof_q <= 1'b0;
      end
      if ((state_q == IDLE) && buf_en_q) busy_q <= 1'b0;

      case (state_q)
        IDLE, GAP: begin
          if (row_start) begin
            buf_en_q   <= 1'b1;
            buf_data_q <= s.s_data;
            wr_col_q   <= '0;
            wr_row_q   <= (state_q == IDLE) ? '0 : row_q;
            row_q      <= (state_q == IDLE) ? '0 : row_q;
            col_q      <= CW'(1);
            busy_q     <= 1'b1;
            state_q    <= ROW;
          end
        end
        ROW: begin
          // Starved cycles still write, repeating the held pixel, so the row keeps its phase.
          buf_en_q <= 1'b1;
          wr_col_q <= col_q;
          wr_row_q <= row_q;
          if (s.s_valid) buf_data_q <= s.s_data;
          else           err_ur_q   <= 1'b1;
          if (col_q == COL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_LAST) begin
              row_q   <= '0;
              state_q <= IDLE;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= GAP;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept && s.s_sof && (state_q != IDLE)) err_sof_q <= 1'b1;
    end
  end

  assign buf_en       = buf_en_q;
  assign buf_data     = buf_data_q;
  assign pair_valid   = pair_valid_q;
  assign pair_col     = pair_col_q;
  assign pair_row     = pair_row_q;
  assign pair_eol     = pair_eol_q;
  assign pair_eof     = pair_eof_q;
  assign frame_done   = pair_eof_q;
  assign frame_busy   = busy_q;
  assign err_underrun = err_ur_q;
  assign err_sof      = err_sof_q;
endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb/tb_line_buf_ctrl.sv - directed scoreboard bench for line_buf_ctrl at 8x4 with a column buffer model
module tb_line_buf_ctrl;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int CW = 3;
  localparam int RW = 2;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          err_clr = 1'b0;
  logic          buf_en, pair_valid, pair_eol, pair_eof;
  logic          frame_busy, frame_done, err_underrun, err_sof;
  logic [DW-1:0] buf_data;
  logic [CW-1:0] pair_col;
  logic [RW-1:0] pair_row;

  line_buf_if #(.DW(DW)) s_if ();

  line_buf_ctrl #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW), .RW(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s_if),
    .buf_en      (buf_en),
    .buf_data    (buf_data),
    .pair_valid  (pair_valid),
    .pair_col    (pair_col),
    .pair_row    (pair_row),
    .pair_eol    (pair_eol),
    .pair_eof    (pair_eof),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .err_underrun(err_underrun),
    .err_sof     (err_sof),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  // Reference phase, column buffer model and write scoreboard
  logic [2:0] tb_phase;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_phase <= 3'd0;
    else        tb_phase <= tb_phase + 3'd1;
  end

  logic [7:0] ring [W];
  logic [7:0] m_buf1, m_buf2;
  always @(posedge clk) begin
    if (buf_en) begin
      m_buf1 <= buf_data;
      m_buf2 <= ring[W-1];
    end
    for (int i = W - 1; i > 0; i--) ring[i] <= ring[i-1];
    ring[0] <= buf_en ? buf_data : ring[W-1];
  end

  wr_t        wq[$];
  logic [7:0] exp_pix [H][W];
  bit         mon_on = 1'b0;
  bit         exp_busy = 1'b0;
  bit         prev_w = 1'b0;
  bit         cur_w;
  wr_t        prev_e = '{0, 0, 8'h00};
  wr_t        cur_e  = '{0, 0, 8'h00};
  int         pair_cnt = 0;
  int         done_cnt = 0;

  task automatic push(input int r, input int c, input logic [7:0] d);
    wq.push_back('{r, c, d});
    exp_pix[r][c] = d;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      cur_w = 1'b0;
      check("frame_busy", frame_busy, exp_busy);
      if (pair_valid) pair_cnt++;
      if (frame_done) done_cnt++;
      if (buf_en) begin
        if (wq.size() == 0) begin
          check("extra_write", buf_en, 0);
        end else begin
          cur_e = wq.pop_front();
          cur_w = 1'b1;
          check("wr_data", buf_data, cur_e.data);
          check("wr_phase", tb_phase, cur_e.col);
          if (cur_e.row == H - 1 && cur_e.col == W - 1) exp_busy = 1'b0;
        end
      end
      if (prev_w && prev_e.row >= 1) begin
        check("pair_valid", pair_valid, 1);
        check("pair_col", pair_col, prev_e.col);
        check("pair_row", pair_row, prev_e.row);
        check("pair_eol", pair_eol, prev_e.col == W - 1);
        check("pair_eof", pair_eof, (prev_e.col == W - 1) && (prev_e.row == H - 1));
        check("frame_done", frame_done, (prev_e.col == W - 1) && (prev_e.row == H - 1));
        check("buf1", m_buf1, prev_e.data);
        check("buf2", m_buf2, exp_pix[prev_e.row-1][prev_e.col]);
      end else begin
        check("no_pair", {pair_valid, pair_eol, pair_eof, frame_done}, 0);
      end
      prev_w = cur_w;
      prev_e = cur_e;
    end
  end

  task automatic beat(input logic [7:0] d, input bit sof);
    int n;
    bit rdy;
    n   = 0;
    rdy = 1'b0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_sof   = sof;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = s_if.s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_if.s_valid = 1'b0;
    s_if.s_sof   = 1'b0;
    if (!rdy) check("accept_timeout", s_if.s_ready, 1);
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n;
    n = 0;
    while (tb_phase != p && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tb_phase != p) check("wait_phase", tb_phase, p);
  endtask

  task automatic send_row(input int r, input int gap, input int pad_col, input int pad_len,
                          input int sof_col, input int clr_col);
    logic [7:0] d, last;
    last = 8'h00;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < W; c++) begin
      if (c >= pad_col && c < pad_col + pad_len) begin
        @(posedge clk);
        #1;
        push(r, c, last);
        check("underrun_set", err_underrun, 1);
      end else begin
        d = (pad_len > 0 && c == pad_col - 1) ? 8'h5A : pix(r, c);
        err_clr = (c == clr_col);
        beat(d, (r == 0 && c == 0) || c == sof_col);
        err_clr = 1'b0;
        if (r == 0 && c == 0) exp_busy = 1'b1;
        push(r, c, d);
        last = d;
        if (c == sof_col)      check("err_sof_set", err_sof, 1);
        else if (c == clr_col) check("err_sof_clr", err_sof, 0);
      end
    end
  endtask

  task automatic end_frame(input bit exp_ur, input bit exp_sof);
    repeat (4) @(posedge clk);
    #1;
    check("pair_count", pair_cnt, 24);
    check("done_count", done_cnt, 1);
    check("sb_empty", wq.size(), 0);
    check("busy_end", frame_busy, 0);
    check("err_underrun", err_underrun, exp_ur);
    check("err_sof", err_sof, exp_sof);
    pair_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_sof   = 1'b0;
    s_if.s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {buf_en, buf_data, pair_valid, pair_col, pair_row, pair_eol, pair_eof,
                          frame_busy, frame_done, err_underrun, err_sof}, 0);
    check("rst_phase", dut.u_phase.phase_q, 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Frame A: sof on the boundary phase, continuous rows
    wait_phase(3'd7);
    for (int r = 0; r < H; r++) send_row(r, 0, 99, 0, -1, -1);
    end_frame(1'b0, 1'b0);

    // Frame B: dropped idle beat, early sof held off, two-cycle starvation in row 1
    beat(8'hEE, 1'b0);
    wait_phase(3'd3);
    s_if.s_valid = 1'b1;
    s_if.s_sof   = 1'b1;
    s_if.s_data  = pix(0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ready_hold", s_if.s_ready, 0);
    end
    send_row(0, 0, 99, 0, -1, -1);
    send_row(1, 0, 4, 2, -1, -1);
    send_row(2, 0, 99, 0, -1, -1);
    send_row(3, 0, 99, 0, -1, -1);
    end_frame(1'b1, 1'b0);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("underrun_clr", err_underrun, 0);

    // Frame C: stretched gap, spurious sof, clear, then sof colliding with clear
    send_row(0, 0, 99, 0, -1, -1);
    send_row(1, 5, 99, 0, -1, -1);
    send_row(2, 0, 99, 0, 2, 5);
    send_row(3, 0, 99, 0, 4, 4);
    end_frame(1'b0, 1'b1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("sof_clr", err_sof, 0);

    // Frame D: reset partway through row 1
    send_row(0, 0, 99, 0, -1, -1);
    for (int c = 0; c < 5; c++) begin
      beat(pix(1, c), 1'b0);
      push(1, c, pix(1, c));
    end
    mon_on = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {buf_en, buf_data, pair_valid, pair_col, pair_row, pair_eol, pair_eof,
                             frame_busy, frame_done, err_underrun, err_sof}, 0);
    check("midrst_phase", dut.u_phase.phase_q, 0);
    wq.delete();
    exp_busy = 1'b0;
    prev_w   = 1'b0;
    pair_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Frame E: clean frame after reset
    for (int r = 0; r < H; r++) send_row(r, 0, 99, 0, -1, -1);
    end_frame(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
